activation_pipe: RTL and testbench

Multi-lane, runtime-selectable activation unit for the MobileNetV3 datapath. Applies identity, ReLU, ReLU6, h-sigmoid or h-swish to LANES signed fixed-point elements per beat. The mode travels with each beat, so consecutive beats may use different functions. Sits between the conv/BN output stage and the next layer's input buffer. The datapath is a 3-stage pipeline with full valid/ready backpressure, optional output requantisation and per-lane saturation flags.

---
 rtl/activation_pipe.sv | 190 +++++++++++++++++++
 tb/tb_activation_pipe.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/activation_pipe.sv
// Multi-lane activation unit (identity/relu/relu6/h-sigmoid/h-swish) with a per-beat mode,
// three-stage valid/ready pipeline, output requantisation and per-lane saturation flags.
module activation_lane #(
    parameter int DATA_WIDTH = 8,
    parameter int FRAC_BITS  = 4,
    parameter int OUT_WIDTH  = 8,
    parameter int OUT_FRAC   = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ld1,
    input  logic                  ld2,
    input  logic                  ld3,
    input  logic [DATA_WIDTH-1:0] x,
    input  logic [2:0]            mode_s1,
    input  logic [2:0]            mode_s2,
    output logic [OUT_WIDTH-1:0]  z,
    output logic                  sat
);
    localparam int XW  = DATA_WIDTH + 2;
    // Wide enough for x * r6 * R without wrapping, plus rounding headroom.
    localparam int PW  = 2 * DATA_WIDTH + 18;
    localparam int D   = FRAC_BITS - OUT_FRAC;
    localparam int DM1 = (D > 0) ? D - 1 : 0;
    localparam logic signed [XW-1:0] THREE    = XW'(3 << FRAC_BITS);
    localparam logic signed [XW-1:0] SIX      = XW'(6 << FRAC_BITS);
    localparam logic signed [PW-1:0] SIX_P    = PW'(6 << FRAC_BITS);
    localparam logic signed [PW-1:0] R        = PW'(10923);
    localparam logic signed [PW-1:0] RND_HSIG = PW'(64'sd1 <<< 15);
    localparam logic signed [PW-1:0] RND_HSW  = PW'(64'sd1 <<< (15 + FRAC_BITS));
    localparam logic signed [PW-1:0] RND_Q    = (D > 0) ? PW'(64'sd1 <<< DM1) : '0;
    localparam logic signed [PW-1:0] MAX_O    = PW'((64'sd1 <<< (OUT_WIDTH - 1)) - 1);
    localparam logic signed [PW-1:0] MIN_O    = PW'(-(64'sd1 <<< (OUT_WIDTH - 1)));

    logic signed [DATA_WIDTH-1:0] x_q, x_d;
    logic signed [XW-1:0]         r6_q, r6_d, sum;
    logic signed [PW-1:0]         v_q, v_d, xp, r6p, y, zr;
    logic [OUT_WIDTH-1:0]         z_q, z_d;
    logic                         sat_q, sat_d;

    always_comb begin
        sum  = XW'(signed'(x)) + THREE;
        x_d  = x_q;
        r6_d = r6_q;
        if (ld1) begin
            x_d = signed'(x);
            if (sum < 0)        r6_d = '0;
            else if (sum > SIX) r6_d = SIX;
            else                r6_d = sum;
        end
    end

    // S2 leaves the value in Q.F for the clamp modes, or the raw product for the hard modes.
    always_comb begin
        xp  = PW'(x_q);
        r6p = PW'(r6_q);
        v_d = v_q;
        if (ld2) begin
            case (mode_s1)
                3'd1:    v_d = (xp < 0) ? '0 : xp;
                3'd2:    v_d = (xp < 0) ? '0 : ((xp > SIX_P) ? SIX_P : xp);
                3'd3:    v_d = r6p * R;
                3'd4:    v_d = xp * r6p * R;
                default: v_d = xp;
            endcase
        end
    end

    always_comb begin
        case (mode_s2)
            3'd3:    y = (v_q + RND_HSIG) >>> 16;
            3'd4:    y = (v_q + RND_HSW) >>> (16 + FRAC_BITS);
            default: y = v_q;
        endcase
        zr    = (y + RND_Q) >>> D;
        z_d   = z_q;
        sat_d = sat_q;
        if (ld3) begin
            sat_d = (zr > MAX_O) || (zr < MIN_O);
            if (zr > MAX_O)      z_d = MAX_O[OUT_WIDTH-1:0];
            else if (zr < MIN_O) z_d = MIN_O[OUT_WIDTH-1:0];
            else                 z_d = zr[OUT_WIDTH-1:0];
        end
    end

    always_ff @(posedge clk) begin
        x_q  <= x_d;
        r6_q <= r6_d;
        v_q  <= v_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            z_q   <= '0;
            sat_q <= 1'b0;
        end else begin
            z_q   <= z_d;
            sat_q <= sat_d;
        end
    end

    assign z   = z_q;
    assign sat = sat_q;
endmodule

module activation_pipe #(
    parameter int LANES      = 4,
    parameter int DATA_WIDTH = 8,
    parameter int FRAC_BITS  = 4,
    parameter int OUT_WIDTH  = DATA_WIDTH,
    parameter int OUT_FRAC   = FRAC_BITS
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [LANES*DATA_WIDTH-1:0]   in_data,
    input  logic [2:0]                    in_mode,
    input  logic                          in_last,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [LANES*OUT_WIDTH-1:0]    out_data,
    output logic                          out_last,
    output logic [LANES-1:0]              out_sat
);
    logic                            v1_q, v1_d, v2_q, v2_d, v3_q, v3_d;
    logic                            last1_q, last1_d, last2_q, last2_d, last3_q, last3_d;
    logic [2:0]                      mode1_q, mode1_d, mode2_q, mode2_d;
    logic                            adv1, adv2, adv3, ld1, ld2, ld3;
    logic [LANES-1:0][OUT_WIDTH-1:0] z;
    logic [LANES-1:0]                sat;

    // A stage advances when empty or when the stage after it advances, so bubbles collapse.
    always_comb begin
        adv3     = !v3_q || out_ready;
        adv2     = !v2_q || adv3;
        adv1     = !v1_q || adv2;
        in_ready = adv1 && !rst;
        ld1      = in_valid && in_ready;
        ld2      = adv2 && v1_q;
        ld3      = adv3 && v2_q;
        v1_d     = adv1 ? ld1 : v1_q;
        v2_d     = adv2 ? v1_q : v2_q;
        v3_d     = adv3 ? v2_q : v3_q;
        mode1_d  = ld1 ? in_mode : mode1_q;
        last1_d  = ld1 ? in_last : last1_q;
        mode2_d  = ld2 ? mode1_q : mode2_q;
        last2_d  = ld2 ? last1_q : last2_q;
        last3_d  = ld3 ? last2_q : last3_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v1_q    <= 1'b0;
            v2_q    <= 1'b0;
            v3_q    <= 1'b0;
            last1_q <= 1'b0;
            last2_q <= 1'b0;
            last3_q <= 1'b0;
            mode1_q <= '0;
            mode2_q <= '0;
        end else begin
            v1_q    <= v1_d;
            v2_q    <= v2_d;
            v3_q    <= v3_d;
            last1_q <= last1_d;
            last2_q <= last2_d;
            last3_q <= last3_d;
            mode1_q <= mode1_d;
            mode2_q <= mode2_d;
        end
    end

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        activation_lane #(
            .DATA_WIDTH(DATA_WIDTH), .FRAC_BITS(FRAC_BITS),
            .OUT_WIDTH(OUT_WIDTH), .OUT_FRAC(OUT_FRAC)
        ) u_lane (
            .clk(clk), .rst(rst), .ld1(ld1), .ld2(ld2), .ld3(ld3),
            .x(in_data[i*DATA_WIDTH +: DATA_WIDTH]),
            .mode_s1(mode1_q), .mode_s2(mode2_q),
            .z(z[i]), .sat(sat[i])
        );
    end

    assign out_valid = v3_q;
    assign out_last  = last3_q;
    assign out_data  = z;
    assign out_sat   = sat;
endmodule

// File: tb/tb_activation_pipe.sv
// Bench for activation_pipe: directed mode/boundary vectors, latency, capacity, reset
// and randomized backpressure traffic scored against an arithmetic reference model.
module tb_activation_pipe;
    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, in_last, out_valid, out_ready, out_last;
    logic [2:0]  in_mode;
    logic [31:0] in_data, out_data;
    logic [3:0]  out_sat;
    logic        rq_in_valid, rq_in_ready, rq_in_last, rq_out_valid, rq_out_ready, rq_out_last;
    logic [2:0]  rq_in_mode;
    logic [31:0] rq_in_data;
    logic [15:0] rq_out_data;
    logic [3:0]  rq_out_sat;

    always #5 clk = ~clk;

    activation_pipe u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_mode(in_mode), .in_last(in_last), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_last(out_last), .out_sat(out_sat)
    );

    activation_pipe #(.OUT_WIDTH(4), .OUT_FRAC(2)) u_rq (
        .clk(clk), .rst(rst), .in_valid(rq_in_valid), .in_ready(rq_in_ready), .in_data(rq_in_data),
        .in_mode(rq_in_mode), .in_last(rq_in_last), .out_valid(rq_out_valid), .out_ready(rq_out_ready),
        .out_data(rq_out_data), .out_last(rq_out_last), .out_sat(rq_out_sat)
    );

    typedef struct {
        logic [31:0] d;
        logic        l;
        logic [3:0]  s;
        int          acc;
    } beat_t;

    beat_t       sb[$];
    int          n_pass = 0, n_chk = 0, cyc = 0, n_emit = 0;
    bit          chk_lat = 0, hold_pend = 0;
    logic [37:0] hold_val;

    logic [31:0] t_in  [10] = '{32'h4020F080, 32'h4020F080, 32'h4020F080, 32'h4020F080, 32'h4020F080,
                                32'h4020F080, 32'h4020F080, 32'h4020F080, 32'h000030D0, 32'h000030D0};
    logic [2:0]  t_md  [10] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd3, 3'd4};
    logic [31:0] t_exp [10] = '{32'h4020F080, 32'h40200000, 32'h40200000, 32'h100D0500, 32'h401BFB00,
                                32'h4020F080, 32'h4020F080, 32'h4020F080, 32'h08081000, 32'h00003000};

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    function automatic int floor_div(int a, int b);
        return (a >= 0) ? a / b : -((-a + b - 1) / b);
    endfunction

    // Activation in Q.4 on plain integers.
    function automatic int act_ref(int x, int m);
        int r6 = x + 48;
        if (r6 < 0)  r6 = 0;
        if (r6 > 96) r6 = 96;
        case (m)
            1:       return (x > 0) ? x : 0;
            2:       return (x < 0) ? 0 : ((x > 96) ? 96 : x);
            3:       return floor_div(r6 * 10923 + 32768, 65536);
            4:       return floor_div(x * r6 * 10923 + 524288, 1048576);
            default: return x;
        endcase
    endfunction

    function automatic beat_t model(input logic [31:0] d, input logic [2:0] m, input logic l);
        beat_t b;
        int    x, y;
        b.d = '0; b.s = '0; b.l = l; b.acc = 0;
        for (int i = 0; i < 4; i++) begin
            x = int'($signed(d[i*8 +: 8]));
            y = act_ref(x, int'(m));
            if (y > 127) begin y = 127; b.s[i] = 1'b1; end
            if (y < -128) begin y = -128; b.s[i] = 1'b1; end
            b.d[i*8 +: 8] = 8'(y);
        end
        return b;
    endfunction

    // One clock: sample handshakes 1 time unit after the falling edge, score, advance.
    task automatic tick(output bit acc);
        beat_t e;
        #1;
        acc = 0;
        if (rst) begin
            chk("rst_in_ready", in_ready, 0);
        end else begin
            if (in_valid && in_ready) begin
                e = model(in_data, in_mode, in_last);
                e.acc = cyc;
                sb.push_back(e);
                acc = 1;
            end
            if (hold_pend) chk("stall_hold", {out_valid, out_last, out_sat, out_data}, hold_val);
            if (out_valid && out_ready) begin
                n_emit++;
                chk("no_stale", sb.size() == 0, 0);
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    chk("data", out_data, e.d);
                    chk("last", out_last, e.l);
                    chk("sat", out_sat, e.s);
                    if (chk_lat) chk("latency", cyc - e.acc, 3);
                end
            end
            hold_pend = out_valid && !out_ready;
            hold_val  = {out_valid, out_last, out_sat, out_data};
        end
        @(negedge clk);
        cyc++;
        if (rst) begin
            sb.delete();
            hold_pend = 0;
        end
    endtask

    task automatic drain();
        bit acc;
        in_valid  = 0;
        out_ready = 1;
        for (int k = 0; k < 20 && sb.size() > 0; k++) tick(acc);
        chk("drain_empty", sb.size(), 0);
    endtask

    task automatic send_one(input logic [31:0] d, input logic [2:0] m,
                            output logic [31:0] gd, output logic [3:0] gs);
        bit acc;
        in_valid = 1; in_data = d; in_mode = m; in_last = 0; out_ready = 1;
        tick(acc);
        chk("one_accept", acc, 1);
        in_valid = 0;
        for (int k = 0; k < 10 && !out_valid; k++) tick(acc);
        chk("one_valid", out_valid, 1);
        gd = out_data;
        gs = out_sat;
        tick(acc);
    endtask

    initial begin
        bit          acc;
        int          cnt, e0, sent, k;
        logic [31:0] gd;
        logic [3:0]  gs;
        logic [2:0]  mix [5] = '{3'd4, 3'd1, 3'd3, 3'd2, 3'd0};

        rst = 1; in_valid = 0; in_data = 0; in_mode = 0; in_last = 0; out_ready = 1;
        rq_in_valid = 0; rq_in_data = 0; rq_in_mode = 0; rq_in_last = 0; rq_out_ready = 1;
        @(negedge clk);
        tick(acc);
        tick(acc);
        rst = 0;
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_last", out_last, 0);
        chk("rst_out_sat", out_sat, 0);
        chk("rst_in_ready_after", in_ready, 1);
        chk("rst_rq_valid", rq_out_valid, 0);

        for (int i = 0; i < 10; i++) begin
            send_one(t_in[i], t_md[i], gd, gs);
            chk($sformatf("mode%0d_row%0d", t_md[i], i), gd, t_exp[i]);
            chk($sformatf("mode%0d_sat%0d", t_md[i], i), gs, 0);
        end

        // back-to-back mixed modes, last marker on the third beat
        chk_lat = 1;
        e0 = n_emit;
        out_ready = 1;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1; in_data = $urandom; in_mode = mix[i]; in_last = (i == 2);
            tick(acc);
            chk("mix_accept", acc, 1);
        end
        drain();
        chk("mix_emits", n_emit - e0, 5);
        chk_lat = 0;

        // capacity with the sink blocked
        out_ready = 0; in_valid = 1; in_last = 0; cnt = 0;
        for (int i = 0; i < 6; i++) begin
            in_data = $urandom; in_mode = 3'($urandom_range(0, 7));
            tick(acc);
            if (acc) cnt++;
        end
        chk("capacity", cnt, 3);
        chk("full_in_ready", in_ready, 0);
        drain();

        // reset with three beats in flight
        out_ready = 0; in_valid = 1;
        for (int i = 0; i < 3; i++) begin
            in_data = $urandom; in_mode = 3'($urandom_range(0, 4));
            tick(acc);
        end
        in_valid = 0;
        rst = 1;
        tick(acc);
        rst = 0;
        #1;
        chk("post_rst_valid", out_valid, 0);
        chk("post_rst_in_ready", in_ready, 1);
        out_ready = 1;
        for (int i = 0; i < 6; i++) tick(acc);
        chk_lat = 1;
        send_one(32'h4020F080, 3'd4, gd, gs);
        chk("post_rst_beat", gd, 32'h401BFB00);
        chk_lat = 0;

        // randomized traffic with 50% sink stalls
        sent = 0; k = 0; in_valid = 0;
        while ((sent < 1000 || sb.size() > 0) && k < 20000) begin
            if (!in_valid && sent < 1000 && $urandom_range(0, 3) != 0) begin
                in_valid = 1; in_data = $urandom;
                in_mode = 3'($urandom_range(0, 7)); in_last = 1'($urandom_range(0, 1));
            end
            out_ready = 1'($urandom_range(0, 1));
            tick(acc);
            if (acc) begin
                sent++;
                in_valid = 0;
            end
            k++;
        end
        chk("random_sent", sent, 1000);
        chk("random_drained", sb.size(), 0);
        drain();

        // requantisation instance: Q.4 -> 4-bit Q.2
        rq_in_valid = 1; rq_in_data = 32'hEC050640; rq_in_mode = 3'd1; rq_out_ready = 1;
        #1;
        chk("rq_in_ready", rq_in_ready, 1);
        @(negedge clk);
        rq_in_valid = 0;
        for (int i = 0; i < 10 && !rq_out_valid; i++) @(negedge clk);
        chk("rq_valid", rq_out_valid, 1);
        chk("rq_data", rq_out_data, 16'h0127);
        chk("rq_sat", rq_out_sat, 4'b0001);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
